// File: rtl/gen_fifo_pack.sv
// gen_fifo_pack: drains a gen_fifo read port and packs N consecutive W-bit
// entries into one N*W-bit word on a valid/ready stream. A flush closes a
// partial word early and tags it last. The first entry popped lands in lane 0.

// One output lane: the accumulator slot plus its slice of the output register.
module gen_fifo_pack_lane #(
  parameter int W     = 8,
  parameter int CNT_W = 3,
  parameter int LANE  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [W-1:0]     wr_data,
  input  logic             ld_out,
  input  logic [CNT_W-1:0] acc_cnt,
  output logic [W-1:0]     out_lane
);
  logic [W-1:0] acc_q;

  // accumulator slot, written by an arriving FIFO entry aimed at this lane
  always_ff @(posedge clk) begin
    if (rst)        acc_q <= '0;
    else if (wr_en) acc_q <= wr_data;
  end

  // output slice; lanes beyond the fill level of a partial word read as zero
  always_ff @(posedge clk) begin
    if (rst)         out_lane <= '0;
    else if (ld_out) out_lane <= (CNT_W'(LANE) < acc_cnt) ? acc_q : '0;
  end
endmodule

module gen_fifo_pack #(
  parameter int W      = 8,
  parameter int N      = 4,
  parameter int RD_LAT = 1,
  parameter int CNT_W  = $clog2(N+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             flush,
  output logic             fifo_rd_en,
  input  logic [W-1:0]     fifo_rd_data,
  input  logic             fifo_rd_empty,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N*W-1:0]   out_data,
  output logic [CNT_W-1:0] out_cnt,
  output logic             out_last,
  output logic             busy
);
  localparam int CW1 = CNT_W + 1;

  logic [CNT_W-1:0]       acc_cnt;
  logic                   acc_last;
  logic                   inflight;   // a pop issued last cycle whose data lands this cycle
  logic                   flush_pend;
  logic                   out_free, xfer, room, arrive;
  logic [CNT_W-1:0]       wr_lane;
  logic [N-1:0]           wr_en_v;
  logic [N-1:0][W-1:0]    out_lanes;

  // transfer decision, pop request and write-lane selection
  always_comb begin
    out_free   = !out_valid || out_ready;
    xfer       = out_free && ((acc_cnt == CNT_W'(N)) ||
                              (flush_pend && !inflight && (acc_cnt != '0)));
    // in-flight entries already own a lane, so they count against the room left
    room       = ({1'b0, acc_cnt} + CW1'(inflight)) < CW1'(N);
    fifo_rd_en = !rst && !clear && !fifo_rd_empty && !flush_pend && (room || xfer);
    arrive     = (RD_LAT == 0) ? fifo_rd_en : inflight;
    // data arriving alongside a transfer starts the next word
    wr_lane    = xfer ? '0 : acc_cnt;
  end

  // accumulator bookkeeping: fill level, in-flight flag and flush request
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      acc_cnt    <= '0;
      acc_last   <= 1'b0;
      inflight   <= 1'b0;
      flush_pend <= 1'b0;
    end else begin
      inflight <= (RD_LAT != 0) && fifo_rd_en;
      if (xfer)        acc_cnt <= arrive ? CNT_W'(1) : '0;
      else if (arrive) acc_cnt <= acc_cnt + CNT_W'(1);
      // a flush landing on an already-full word marks that word last
      acc_last <= xfer ? 1'b0 : (acc_last || (flush && (acc_cnt == CNT_W'(N))));
      if (flush && !flush_pend)
        flush_pend <= 1'b1;
      else if (xfer || (flush_pend && (acc_cnt == '0) && !inflight))
        flush_pend <= 1'b0;
    end
  end

  // output register control; payload is held stable while stalled
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_cnt   <= '0;
      out_last  <= 1'b0;
    end else if (clear) begin
      out_valid <= 1'b0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_cnt   <= acc_cnt;
      out_last  <= acc_last || flush_pend;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  for (genvar k = 0; k < N; k++) begin : g_lane
    assign wr_en_v[k] = arrive && !clear && (wr_lane == CNT_W'(k));
    gen_fifo_pack_lane #(.W(W), .CNT_W(CNT_W), .LANE(k)) u_lane (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_en_v[k]),
      .wr_data (fifo_rd_data),
      .ld_out  (xfer && !clear),
      .acc_cnt (acc_cnt),
      .out_lane(out_lanes[k])
    );
  end

  assign out_data = out_lanes;
  assign busy     = (acc_cnt != '0) || inflight || flush_pend;
endmodule

// File: tb/tb_gen_fifo_pack.sv
// Bench for gen_fifo_pack: one instance per read latency (index = RD_LAT),
// each fed by a queue-based FIFO model. Expected words come from the pushed
// entry sequence grouped N at a time; a monitor pops them on each handshake.
module tb_gen_fifo_pack;
  localparam int W = 8, N = 4, CNT_W = $clog2(N+1);

  typedef struct { logic [N*W-1:0] d; int cnt; bit last; } word_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]              rst, clear, flush, rd_en, empty, out_valid, out_ready, out_last, busy;
  logic [1:0][W-1:0]       rd_data;
  logic [1:0][N*W-1:0]     out_data;
  logic [1:0][CNT_W-1:0]   out_cnt;

  gen_fifo_pack #(.W(W), .N(N), .RD_LAT(0)) u_dut0 (
    .clk(clk), .rst(rst[0]), .clear(clear[0]), .flush(flush[0]),
    .fifo_rd_en(rd_en[0]), .fifo_rd_data(rd_data[0]), .fifo_rd_empty(empty[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
    .out_cnt(out_cnt[0]), .out_last(out_last[0]), .busy(busy[0]));

  gen_fifo_pack #(.W(W), .N(N), .RD_LAT(1)) u_dut1 (
    .clk(clk), .rst(rst[1]), .clear(clear[1]), .flush(flush[1]),
    .fifo_rd_en(rd_en[1]), .fifo_rd_data(rd_data[1]), .fifo_rd_empty(empty[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
    .out_cnt(out_cnt[1]), .out_last(out_last[1]), .busy(busy[1]));

  word_t          exp0[$], exp1[$];
  logic [W-1:0]   fq0[$], fq1[$], pend0[$], pend1[$];
  int             vt0[$], vt1[$];
  int             ri[2], pop_cnt[2], gate_err[2], first_pop[2];
  bit             arm[2];
  int             cyc, n_pass, n_tot, pc, nv, unstable, k;
  bit             done;
  logic [N*W-1:0] held;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] expv);
    n_tot++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, expv);
  endtask

  task automatic fifo_upd(int s);
    if (s == 0) begin
      empty[0]   = (fq0.size() == 0);
      rd_data[0] = (fq0.size() != 0) ? fq0[0] : '0;
    end else begin
      empty[1] = (fq1.size() == 0);
    end
  endtask

  // close the current model word from the pending entries
  task automatic emit(int s, bit last);
    word_t w;
    w.d = '0; w.last = last;
    if (s == 0) begin
      w.cnt = pend0.size();
      foreach (pend0[i]) w.d[i*W +: W] = pend0[i];
      exp0.push_back(w); pend0.delete();
    end else begin
      w.cnt = pend1.size();
      foreach (pend1[i]) w.d[i*W +: W] = pend1[i];
      exp1.push_back(w); pend1.delete();
    end
  endtask

  task automatic push(int s, logic [W-1:0] v);
    int n;
    if (s == 0) begin fq0.push_back(v); pend0.push_back(v); n = pend0.size(); end
    else        begin fq1.push_back(v); pend1.push_back(v); n = pend1.size(); end
    if (n == N) emit(s, 1'b0);
    fifo_upd(s);
  endtask

  task automatic model_flush(int s);
    if (((s == 0) ? pend0.size() : pend1.size()) > 0) emit(s, 1'b1);
  endtask

  // reset/clear: everything not yet delivered is gone
  task automatic model_drop(int s);
    if (s == 0) begin pend0.delete(); while (exp0.size() > ri[0]) void'(exp0.pop_back()); end
    else        begin pend1.delete(); while (exp1.size() > ri[1]) void'(exp1.pop_back()); end
  endtask

  // one clock: sample pops mid-cycle, retire them just after the edge
  task automatic tick();
    logic [1:0] p;
    logic [W-1:0] v;
    @(negedge clk);
    p = rd_en;
    for (int s = 0; s < 2; s++) if (rd_en[s] && empty[s]) gate_err[s]++;
    @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) if (p[s] && !empty[s]) begin
      if (s == 0) v = fq0.pop_front();
      else begin v = fq1.pop_front(); rd_data[1] = v; end
      pop_cnt[s]++;
      if (arm[s]) begin first_pop[s] = cyc; arm[s] = 1'b0; end
      fifo_upd(s);
    end
    cyc++;
  endtask

  task automatic mon_one(int s);
    word_t w;
    int sz;
    sz = (s == 0) ? exp0.size() : exp1.size();
    if (ri[s] >= sz) begin
      n_tot++;
      $display("FAIL unexpected_word dut%0d: got %h expected none", s, out_data[s]);
    end else begin
      if (s == 0) w = exp0[ri[s]]; else w = exp1[ri[s]];
      n_tot++;
      if (out_data[s] === w.d && out_cnt[s] === CNT_W'(w.cnt) && out_last[s] === w.last) n_pass++;
      else $display("FAIL word dut%0d #%0d: got %h/%0d/%0d expected %h/%0d/%0d",
                    s, ri[s], out_data[s], out_cnt[s], out_last[s], w.d, w.cnt, w.last);
      ri[s]++;
      if (s == 0) vt0.push_back(cyc); else vt1.push_back(cyc);
    end
  endtask

  task automatic chk_idle(int s, string nm);
    chk({nm, "_valid"}, out_valid[s], 0);
    chk({nm, "_data"},  out_data[s], 0);
    chk({nm, "_cnt"},   out_cnt[s], 0);
    chk({nm, "_last"},  out_last[s], 0);
    chk({nm, "_busy"},  busy[s], 0);
    chk({nm, "_rden"},  rd_en[s], 0);
  endtask

  initial begin
    rst = 2'b11; clear = '0; flush = '0; out_ready = 2'b11; empty = 2'b11; rd_data = '0;
    cyc = 0; n_pass = 0; n_tot = 0; done = 1'b0;
    for (int s = 0; s < 2; s++) begin ri[s] = 0; pop_cnt[s] = 0; gate_err[s] = 0; first_pop[s] = 0; arm[s] = 1'b0; end
    fork
      begin : mon
        while (!done) begin
          @(negedge clk);
          for (int s = 0; s < 2; s++) if (out_valid[s] && out_ready[s]) mon_one(s);
        end
      end
      begin : stim
        repeat (3) tick();
        rst = '0;
        tick();
        chk_idle(0, "rst0");
        chk_idle(1, "rst1");

        // full-rate packing, RD_LAT = 1
        arm[1] = 1'b1; vt1.delete();
        for (int i = 0; i < 8; i++) push(1, W'(i));
        repeat (14) tick();
        chk("fr1_lat_first", (vt1.size() > 0) ? vt1[0] - first_pop[1] : -1, 6);
        chk("fr1_lat_next",  (vt1.size() > 1) ? vt1[1] - vt1[0] : -1, 5);

        // partial flush
        push(1, 8'hA1); push(1, 8'hA2);
        repeat (5) tick();
        flush[1] = 1'b1; model_flush(1); tick(); flush[1] = 1'b0;
        pc = pop_cnt[1];
        repeat (6) tick();
        chk("pf_busy", busy[1], 0);
        chk("pf_nopop", pop_cnt[1] - pc, 0);
        chk("pf_delivered", ri[1], exp1.size());

        // empty flush
        nv = ri[1];
        flush[1] = 1'b1; tick(); flush[1] = 1'b0;
        chk("ef_pend", busy[1], 1);
        tick();
        chk("ef_clr", busy[1], 0);
        repeat (3) tick();
        chk("ef_noword", ri[1], nv);

        // back-pressure
        out_ready[1] = 1'b0; pc = pop_cnt[1];
        for (int i = 0; i < 12; i++) push(1, W'($urandom));
        repeat (8) tick();
        held = out_data[1]; unstable = 0;
        repeat (20) begin
          tick();
          if (out_data[1] !== held || out_valid[1] !== 1'b1) unstable++;
        end
        chk("bp_stable", unstable, 0);
        chk("bp_pops", pop_cnt[1] - pc, 8);
        chk("bp_rden_low", rd_en[1], 0);
        out_ready[1] = 1'b1;
        #1;
        chk("bp_resume", rd_en[1], 1);
        repeat (20) tick();
        chk("bp_delivered", ri[1], exp1.size());

        // clear with acc_cnt = 2 and one entry in flight
        for (int i = 0; i < 3; i++) push(1, W'($urandom));
        repeat (3) tick();
        chk("clr_pre_busy", busy[1], 1);
        clear[1] = 1'b1; model_drop(1); tick(); clear[1] = 1'b0;
        chk("clr_valid", out_valid[1], 0);
        chk("clr_busy", busy[1], 0);
        for (int i = 0; i < 4; i++) push(1, W'(8'hC0 + i));
        repeat (10) tick();
        chk("clr_delivered", ri[1], exp1.size());

        // mid-operation reset on the RD_LAT = 0 instance
        out_ready[0] = 1'b0;
        for (int i = 0; i < 6; i++) push(0, W'($urandom));
        repeat (8) tick();
        chk("mr_pre_valid", out_valid[0], 1);
        rst[0] = 1'b1; model_drop(0); tick(); rst[0] = 1'b0;
        chk_idle(0, "mr");
        out_ready[0] = 1'b1;

        // full-rate packing, RD_LAT = 0
        arm[0] = 1'b1; vt0.delete();
        for (int i = 0; i < 8; i++) push(0, W'(i));
        repeat (12) tick();
        chk("fr0_lat_first", (vt0.size() > 0) ? vt0[0] - first_pop[0] : -1, 5);
        chk("fr0_lat_next",  (vt0.size() > 1) ? vt0[1] - vt0[0] : -1, 4);
        chk("fr0_delivered", ri[0], exp0.size());

        // randomized traffic with random back-pressure, closed by a flush
        for (int s = 0; s < 2; s++) begin
          repeat (400) begin
            if ($urandom_range(0, 2) != 0) push(s, W'($urandom));
            out_ready[s] = ($urandom_range(0, 3) != 0);
            tick();
          end
          out_ready[s] = 1'b1;
          k = 0;
          while (((s == 0) ? fq0.size() : fq1.size()) != 0 && k < 600) begin tick(); k++; end
          chk("rs_drain", k < 600, 1);
          repeat (4) tick();
          flush[s] = 1'b1; model_flush(s); tick(); flush[s] = 1'b0;
          repeat (8) tick();
          chk("rs_delivered", ri[s], (s == 0) ? exp0.size() : exp1.size());
          chk("rs_idle", busy[s], 0);
        end

        chk("rden_gate0", gate_err[0], 0);
        chk("rden_gate1", gate_err[1], 0);
        done = 1'b1;
      end
    join
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
